// File: rtl/regstore_32x32.sv
// 32 x WIDTH register storage with a 5:32 write decoder; register ZERO_REG always reads 0.
// Optional same-cycle write-through bypass is enabled by defining REGSTORE_WRITE_THROUGH_EN.
module regstore_32x32 #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] regs [32]
);

    logic [3:0]  bank_en;
    logic [31:0] e;
    logic        unused_zero_en;

    // First decode stage (2:4) also carries RegWrite, so an unknown index with
    // RegWrite low still resolves every enable to 0.
    always_comb begin
        bank_en = '0;
        for (int b = 0; b < 4; b++) begin
            bank_en[b] = RegWrite && (WriteRegister[4:3] == 2'(b));
        end
    end

    always_comb begin
        e = '0;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 8; r++) begin
                e[b*8 + r] = bank_en[b] && (WriteRegister[2:0] == 3'(r));
            end
        end
    end

    // The zero register's enable is decoded but drives nothing.
    assign unused_zero_en = e[ZERO_REG];

    for (genvar k = 0; k < 32; k++) begin : g_reg
        if (k == ZERO_REG) begin : g_zero
            assign regs[k] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (e[k]) begin
                    q <= WriteData;
                end
            end

`ifdef REGSTORE_WRITE_THROUGH_EN
            // Bypass is suppressed during reset so every entry reads 0 while reset is high.
            assign regs[k] = (e[k] && !reset) ? WriteData : q;
`else
            assign regs[k] = q;
`endif
        end
    end

endmodule

// File: tb/tb_regstore_32x32.sv
// Self-checking bench for regstore_32x32: table-driven write vectors plus
// hand-written reset, mid-write reset and same-cycle read sequences.
module tb_regstore_32x32;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] regs [32];

    logic [31:0] model [32];
    int          checks;
    int          failures;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          chk;
        logic [31:0] expect_val;
    } vec_t;

    vec_t vecs [$];

    regstore_32x32 dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .regs         (regs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("%s_r%0d", name, i), regs[i], model[i]);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, then settle 1 time unit.
    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = addr;
        WriteData     = data;
        @(posedge clk);
        #1;
        if (we === 1'b1 && addr != 5'd31) model[addr] = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        #12;
        reset = 1'b0;

        // Give some registers arbitrary contents before reset is tested
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(i * 5), $urandom);
        end

        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        checkAll("async_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkAll("post_reset_idle");

        // Vector table: walking write, zero register, disabled writes, unknown index with write off
        for (int k = 0; k < 31; k++) begin
            vecs.push_back('{1'b1, 5'(k), 32'hA5A50000 + k, k, 32'hA5A50000 + k});
        end
        vecs.push_back('{1'b1, 5'd31, 32'hFFFFFFFF, 31, 32'h00000000});
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b0, 5'd5, 32'hDEADBEEF, 5, 32'hA5A50005});
        end
        vecs.push_back('{1'b0, 5'bxxxxx, 32'hDEADBEEF, 9, 32'hA5A50009});

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].data);
            checkOutput($sformatf("vec%0d_target", v), regs[vecs[v].chk], vecs[v].expect_val);
            checkAll($sformatf("vec%0d", v));
        end

        for (int k = 0; k < 31; k++) begin
            checkOutput($sformatf("sweep_r%0d", k), regs[k], 32'hA5A50000 + k);
        end
        checkOutput("sweep_r31", regs[31], 32'h00000000);

        // Reset pulsed mid-write: the pending write to 7 must be lost
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 32'h12345678;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midwrite_r7_during_reset", regs[7], 32'h00000000);
        for (int i = 0; i < 32; i++) model[i] = '0;
        checkAll("midwrite_reset");
        @(negedge clk);
        reset    = 1'b0;
        RegWrite = 1'b0;
        checkOutput("midwrite_r7_after_edge", regs[7], 32'h00000000);
        applyStimulus(1'b1, 5'd7, 32'h00000001);
        checkOutput("midwrite_r7_rewrite", regs[7], 32'h00000001);

        // Same-cycle read of register 3
        applyStimulus(1'b1, 5'd3, 32'h33333333);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 32'h0BADF00D;
        #1;
`ifdef REGSTORE_WRITE_THROUGH_EN
        checkOutput("same_cycle_pre_edge", regs[3], 32'h0BADF00D);
`else
        checkOutput("same_cycle_pre_edge", regs[3], 32'h33333333);
`endif
        checkOutput("same_cycle_r31_pre_edge", regs[31], 32'h00000000);
        @(posedge clk);
        #1;
        model[3] = 32'h0BADF00D;
        checkOutput("same_cycle_post_edge", regs[3], 32'h0BADF00D);
        checkAll("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
